// File: rtl/ro_word_reader_if.sv
// Byte-select link to the entropy buffer plus the valid/ready byte stream,
// grouped so the reader and its neighbours connect through one bundle.
interface ro_word_reader_if;
  logic [2:0] out_sel;
  logic [7:0] rng_byte;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (
    output out_sel,
    output m_data,
    output m_valid,
    input  rng_byte,
    input  m_ready
  );

  modport slave (
    input  out_sel,
    input  m_data,
    input  m_valid,
    output rng_byte,
    output m_ready
  );
endinterface

// File: rtl/ro_word_reader.sv
// Harvests 64-bit words from the ring-oscillator entropy buffer, health-checks
// each one and streams passing words out as bytes, LSB byte first.
module ro_word_reader #(
  parameter int unsigned REFRESH_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  ro_word_reader_if.master        bus,
  output logic                    health_fail,
  output logic [15:0]             word_count
);

  typedef enum logic [2:0] {
    IDLE, WAIT, FETCH, CAPTURE, CHECK, SEND
  } state_t;

  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  out_sel_q, out_sel_d;
  logic [2:0]  sel_prev_q;
  logic [63:0] word_q, word_d;
  logic [63:0] prev_word_q, prev_word_d;
  logic        prev_valid_q, prev_valid_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  byte_nxt;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        health_fail_q, health_fail_d;
  logic [15:0] word_count_q, word_count_d;
  logic        word_bad;

  assign bus.out_sel  = out_sel_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_valid  = m_valid_q;
  assign health_fail  = health_fail_q;
  assign word_count   = word_count_q;

  assign word_bad = (word_q == '0) || (word_q == '1) ||
                    (prev_valid_q && (word_q == prev_word_q));
  assign byte_nxt = byte_idx_q + 3'd1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    out_sel_d     = '0;
    word_d        = word_q;
    prev_word_d   = prev_word_q;
    prev_valid_d  = prev_valid_q;
    byte_idx_d    = byte_idx_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q;
    health_fail_d = health_fail_q;
    word_count_d  = word_count_q;

    // The buffer answers one cycle late, so store under the select issued last cycle.
    if (((state_q == FETCH) && (out_sel_q != '0)) || (state_q == CAPTURE))
      word_d[{sel_prev_q, 3'b000} +: 8] = bus.rng_byte;

    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == REFRESH_LAST) state_d = FETCH;
        else                       cnt_d   = cnt_q + 16'd1;
      end
      FETCH: begin
        if (out_sel_q == 3'd7) state_d   = CAPTURE;
        else                   out_sel_d = out_sel_q + 3'd1;
      end
      CAPTURE: state_d = CHECK;
      CHECK: begin
        prev_word_d  = word_q;
        prev_valid_d = 1'b1;
        if (word_bad) begin
          health_fail_d = 1'b1;
          state_d       = enable ? WAIT : IDLE;
        end else begin
          state_d    = SEND;
          byte_idx_d = '0;
          m_data_d   = word_q[7:0];
          m_valid_d  = 1'b1;
        end
      end
      SEND: begin
        if (m_valid_q && bus.m_ready) begin
          if (byte_idx_q == 3'd7) begin
            m_valid_d    = 1'b0;
            word_count_d = word_count_q + 16'd1;
            state_d      = enable ? WAIT : IDLE;
          end else begin
            byte_idx_d = byte_nxt;
            m_data_d   = word_q[{byte_nxt, 3'b000} +: 8];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      out_sel_q     <= '0;
      sel_prev_q    <= '0;
      word_q        <= '0;
      prev_word_q   <= '0;
      prev_valid_q  <= 1'b0;
      byte_idx_q    <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      health_fail_q <= 1'b0;
      word_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_sel_q     <= out_sel_d;
      sel_prev_q    <= out_sel_q;
      word_q        <= word_d;
      prev_word_q   <= prev_word_d;
      prev_valid_q  <= prev_valid_d;
      byte_idx_q    <= byte_idx_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      health_fail_q <= health_fail_d;
      word_count_q  <= word_count_d;
    end
  end

endmodule

// File: tb/tb_ro_word_reader.sv
// Directed bench for ro_word_reader: a 1-cycle-latency buffer model feeds two
// readers (refresh 64 and refresh 1); cycle numbers count from the enable edge.
module tb_ro_word_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable, enable_b;
  logic        health_fail, health_fail_b;
  logic [15:0] word_count, word_count_b;

  ro_word_reader_if bus_a ();
  ro_word_reader_if bus_b ();

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int          cyc         = 0;
  logic [1:0]  mode        = 2'd0;   // 0: 0xA0|sel, 1: stuck 0x00, 2: constant 0x5A

  ro_word_reader #(.REFRESH_CYCLES(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bus         (bus_a),
    .health_fail (health_fail),
    .word_count  (word_count)
  );

  ro_word_reader #(.REFRESH_CYCLES(1)) dut_r1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable_b),
    .bus         (bus_b),
    .health_fail (health_fail_b),
    .word_count  (word_count_b)
  );

  function automatic logic [7:0] model(input logic [2:0] sel);
    case (mode)
      2'd1:    return 8'h00;
      2'd2:    return 8'h5A;
      default: return 8'hA0 | {5'd0, sel};
    endcase
  endfunction

  always @(posedge clk) begin
    bus_a.rng_byte <= model(bus_a.out_sel);
    bus_b.rng_byte <= model(bus_b.out_sel);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Present enable at edge E; afterwards cyc == 1 is the first cycle after E.
  task automatic start(input logic hold);
    enable = 1'b1;
    tick();
    cyc    = 1;
    enable = hold;
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b1;
    enable_b      = 1'b0;
    bus_a.m_ready = 1'b1;
    bus_b.m_ready = 1'b1;

    // Reset held 2 cycles with enable high
    tick();
    tick();
    chk("rst_out_sel",     bus_a.out_sel,   0);
    chk("rst_m_data",      bus_a.m_data,    0);
    chk("rst_m_valid",     bus_a.m_valid,   0);
    chk("rst_health_fail", health_fail,     0);
    chk("rst_word_count",  word_count,      0);

    // Nominal word
    rst_n = 1'b1;
    start(1'b0);
    goto(64);
    chk("wait_out_sel", bus_a.out_sel, 0);
    for (int k = 0; k < 8; k++) begin
      goto(65 + k);
      chk("fetch_out_sel", bus_a.out_sel, k);
    end
    goto(73);
    chk("capture_out_sel", bus_a.out_sel, 0);
    goto(74);
    chk("check_no_valid", bus_a.m_valid, 0);
    for (int k = 0; k < 8; k++) begin
      goto(75 + k);
      chk("nom_valid", bus_a.m_valid, 1);
      chk("nom_data",  bus_a.m_data,  8'hA0 + k);
    end
    chk("nom_wc_before", word_count, 0);
    goto(83);
    chk("nom_valid_end", bus_a.m_valid, 0);
    chk("nom_wc",        word_count,    1);
    chk("nom_health",    health_fail,   0);

    // Backpressure on byte 3
    do_reset();
    start(1'b0);
    goto(75);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        bus_a.m_ready = 1'b0;
        repeat (5) begin
          chk("bp_hold_data",  bus_a.m_data,  8'hA3);
          chk("bp_hold_valid", bus_a.m_valid, 1);
          tick();
        end
        bus_a.m_ready = 1'b1;
      end
      chk("bp_data",  bus_a.m_data,  8'hA0 + k);
      chk("bp_valid", bus_a.m_valid, 1);
      tick();
    end
    chk("bp_valid_end", bus_a.m_valid, 0);
    chk("bp_wc",        word_count,    1);

    // Stuck-at-zero word is dropped, then a good word still goes out
    mode = 2'd1;
    start(1'b0);
    goto(74);
    chk("stuck_health_pre", health_fail, 0);
    goto(75);
    chk("stuck_health", health_fail, 1);
    for (int c = 75; c < 85; c++) begin
      goto(c);
      chk("stuck_no_valid", bus_a.m_valid, 0);
    end
    chk("stuck_wc", word_count, 1);
    mode = 2'd0;
    start(1'b0);
    for (int k = 0; k < 8; k++) begin
      goto(75 + k);
      chk("recov_data", bus_a.m_data, 8'hA0 + k);
    end
    goto(83);
    chk("recov_wc",     word_count,  2);
    chk("recov_health", health_fail, 1);

    // Repeated word: second copy discarded
    do_reset();
    mode = 2'd2;
    start(1'b1);
    for (int k = 0; k < 8; k++) begin
      goto(75 + k);
      chk("rep_valid", bus_a.m_valid, 1);
      chk("rep_data",  bus_a.m_data,  8'h5A);
    end
    goto(83);
    chk("rep_wc1", word_count, 1);
    enable = 1'b0;
    goto(156);
    chk("rep_health_pre", health_fail, 0);
    goto(157);
    chk("rep_health", health_fail, 1);
    for (int c = 157; c < 166; c++) begin
      goto(c);
      chk("rep_no_valid", bus_a.m_valid, 0);
    end
    chk("rep_wc2", word_count, 1);

    // Enable dropped during byte 2: word completes, then idle
    do_reset();
    mode = 2'd0;
    start(1'b1);
    for (int k = 0; k < 8; k++) begin
      goto(75 + k);
      if (k == 2) enable = 1'b0;
      chk("en_drop_data", bus_a.m_data, 8'hA0 + k);
    end
    goto(83);
    chk("en_drop_valid", bus_a.m_valid, 0);
    chk("en_drop_wc",    word_count,    1);
    for (int c = 83; c < 163; c += 4) begin
      goto(c);
      chk("idle_out_sel", bus_a.out_sel, 0);
      chk("idle_valid",   bus_a.m_valid, 0);
    end

    // Reset during SEND
    do_reset();
    start(1'b0);
    goto(77);
    chk("mid_rst_pre_valid", bus_a.m_valid, 1);
    chk("mid_rst_pre_data",  bus_a.m_data,  8'hA2);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", bus_a.m_valid, 0);
    chk("mid_rst_wc",    word_count,    0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("mid_rst_stay", bus_a.m_valid, 0);

    // Refresh of 1 cycle on the second reader
    enable_b = 1'b1;
    tick();
    cyc      = 1;
    enable_b = 1'b0;
    goto(11);
    chk("r1_no_valid", bus_b.m_valid, 0);
    for (int k = 0; k < 8; k++) begin
      goto(12 + k);
      chk("r1_valid", bus_b.m_valid, 1);
      chk("r1_data",  bus_b.m_data,  8'hA0 + k);
    end
    goto(20);
    chk("r1_wc", word_count_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
